// File: rtl/palette_write_ctrl.sv
// Palette RAM write-side controller: CPU address/data writes with auto-increment, bulk fill.
// Optional build macro PAL_MIRROR_EN mirrors universal-color writes into the other half.
module palette_write_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 6,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_we,
  input  logic              data_we,
  input  logic [7:0]        cpu_data,
  input  logic              fill_start,
  output logic              busy,
  output logic              overrun,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din
);

`ifdef PAL_MIRROR_EN
  typedef enum logic [1:0] {IDLE, WRITE, MIRROR, FILL} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W-1:0] INC  = ADDR_W'(AUTO_INC);

  state_t state;
  logic   any_cmd;
  logic   unused_cpu_bits;

  assign any_cmd         = fill_start | data_we | addr_we;
  assign unused_cpu_bits = ^cpu_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      cur_addr <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fill_start) begin
            state    <= FILL;
            busy     <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= '0;
            ram_din  <= cpu_data[DATA_W-1:0];
            if (data_we | addr_we) overrun <= 1'b1;
          end else if (data_we) begin
            // ram_addr keeps the pre-increment address for the mirror decision
            state    <= WRITE;
            busy     <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= cur_addr;
            ram_din  <= cpu_data[DATA_W-1:0];
            cur_addr <= addr_we ? cpu_data[ADDR_W-1:0] : cur_addr + INC;
          end else if (addr_we) begin
            cur_addr <= cpu_data[ADDR_W-1:0];
          end
        end
        WRITE: begin
`ifdef PAL_MIRROR_EN
          if (ram_addr[1:0] == 2'b00) begin
            state    <= MIRROR;
            ram_addr <= {~ram_addr[ADDR_W-1], ram_addr[ADDR_W-2:0]};
          end else
`endif
          begin
            state  <= IDLE;
            busy   <= 1'b0;
            ram_we <= 1'b0;
          end
        end
`ifdef PAL_MIRROR_EN
        MIRROR: begin
          state  <= IDLE;
          busy   <= 1'b0;
          ram_we <= 1'b0;
        end
`endif
        FILL: begin
          if (ram_addr == LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ram_we   <= 1'b0;
            cur_addr <= '0;
          end else begin
            ram_addr <= ram_addr + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          ram_we <= 1'b0;
        end
      endcase

      if (state != IDLE && any_cmd) overrun <= 1'b1;
    end
  end

endmodule
